// File: rtl/id_ex_pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_ctrl_if
//
// Purpose:
//   Bundles the decode-side inputs, the writeback bypass port, the stall/flush
//   controls and the execute-side outputs of the ID/EX pipeline register.
//
// Signal summary:
//   id_valid, id_rd1, id_rd2, id_se_offset, id_opcode, id_fn_offset,
//   id_ra1, id_ra2, id_uses_ra1, id_uses_ra2, id_ctrl   decode bundle
//   hazard, flush                                       pipeline control
//   wb_we, wb_addr, wb_data                             writeback bypass
//   ex_valid, ex_rd1, ex_rd2, ex_se_offset, ex_opcode,
//   ex_ra1, ex_ra2, ex_fn_offset, ex_ctrl                execute bundle
//   stall_id                                            IF/ID hold request
//
// Handshake: there is no valid/ready pair here. id_valid marks a real
// instruction in decode; the register accepts it on a rising edge unless
// stall_id is high during that cycle, in which case the upstream stage must
// present the same instruction again on the next cycle. ex_valid marks a
// real instruction in execute; a bubble always has ex_valid=0 and ex_ctrl=0.
//
// Modports:
//   master : the surrounding pipeline (drives id_*, hazard, flush, wb_*)
//   slave  : the ID/EX register itself (drives ex_* and stall_id)
// -----------------------------------------------------------------------------
interface id_ex_pipe_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int RA_W   = 4,
    parameter int OP_W   = 4,
    parameter int FN_W   = 4
);
    // decode bundle
    logic              id_valid;
    logic [DATA_W-1:0] id_rd1;
    logic [DATA_W-1:0] id_rd2;
    logic [DATA_W-1:0] id_se_offset;
    logic [OP_W-1:0]   id_opcode;
    logic [FN_W-1:0]   id_fn_offset;
    logic [RA_W-1:0]   id_ra1;
    logic [RA_W-1:0]   id_ra2;
    logic              id_uses_ra1;
    logic              id_uses_ra2;
    logic [5:0]        id_ctrl;

    // pipeline control
    logic              hazard;
    logic              flush;

    // writeback bypass
    logic              wb_we;
    logic [RA_W-1:0]   wb_addr;
    logic [DATA_W-1:0] wb_data;

    // execute bundle
    logic              ex_valid;
    logic [DATA_W-1:0] ex_rd1;
    logic [DATA_W-1:0] ex_rd2;
    logic [DATA_W-1:0] ex_se_offset;
    logic [OP_W-1:0]   ex_opcode;
    logic [RA_W-1:0]   ex_ra1;
    logic [RA_W-1:0]   ex_ra2;
    logic [FN_W-1:0]   ex_fn_offset;
    logic [5:0]        ex_ctrl;

    // hold request back to IF/ID
    logic              stall_id;

    modport master (
        output id_valid, id_rd1, id_rd2, id_se_offset, id_opcode, id_fn_offset,
               id_ra1, id_ra2, id_uses_ra1, id_uses_ra2, id_ctrl,
               hazard, flush, wb_we, wb_addr, wb_data,
        input  ex_valid, ex_rd1, ex_rd2, ex_se_offset, ex_opcode,
               ex_ra1, ex_ra2, ex_fn_offset, ex_ctrl, stall_id
    );

    modport slave (
        input  id_valid, id_rd1, id_rd2, id_se_offset, id_opcode, id_fn_offset,
               id_ra1, id_ra2, id_uses_ra1, id_uses_ra2, id_ctrl,
               hazard, flush, wb_we, wb_addr, wb_data,
        output ex_valid, ex_rd1, ex_rd2, ex_se_offset, ex_opcode,
               ex_ra1, ex_ra2, ex_fn_offset, ex_ctrl, stall_id
    );
endinterface

// File: rtl/id_ex_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_ctrl
//
// Purpose:
//   Decode-to-execute pipeline register for the 16-bit pipelined core.
//   Captures the decode bundle, inserts a bubble on a load-use hazard or a
//   taken-branch flush, freezes under an external hazard stall, bypasses
//   same-cycle writeback data into the captured operands, and counts the
//   bubbles it inserts in a saturating performance counter.
//
// Ports:
//   clk           clock, all state on the rising edge
//   reset         synchronous, active-high
//   perf_clr      synchronous clear of bubble_count
//   bubble_count  saturating count of inserted bubbles (registered)
//   bus           id_ex_pipe_ctrl_if.slave: decode inputs, hazard/flush,
//                 writeback bypass, registered EX outputs, combinational
//                 stall_id
//
// Per-edge priority of the EX register:
//   reset > flush (bubble) > hazard (hold) > load-use (bubble) > capture
// -----------------------------------------------------------------------------
module id_ex_pipe_ctrl #(
    parameter int DATA_W = 16,
    parameter int RA_W   = 4,
    parameter int OP_W   = 4,
    parameter int FN_W   = 4,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  perf_clr,
    output logic [CNT_W-1:0]      bubble_count,
    id_ex_pipe_ctrl_if.slave      bus
);

    // id_ctrl / ex_ctrl bit positions
    localparam int CTRL_REG_WRITE = 5;
    localparam int CTRL_MEM_READ  = 2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // -------------------------------------------------------------------------
    // EX state
    // -------------------------------------------------------------------------
    logic              ex_valid_q;
    logic [DATA_W-1:0] ex_rd1_q;
    logic [DATA_W-1:0] ex_rd2_q;
    logic [DATA_W-1:0] ex_se_offset_q;
    logic [OP_W-1:0]   ex_opcode_q;
    logic [RA_W-1:0]   ex_ra1_q;
    logic [RA_W-1:0]   ex_ra2_q;
    logic [FN_W-1:0]   ex_fn_offset_q;
    logic [5:0]        ex_ctrl_q;
    logic [CNT_W-1:0]  bubble_count_q;

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    logic ex_is_load;
    logic ra1_dep;
    logic ra2_dep;
    logic load_use;
    logic insert_bubble;

    // A load in EX writes its result into ex_ra1. Register 0 is a real
    // register here, so no special case for address zero.
    assign ex_is_load = ex_valid_q
                      & ex_ctrl_q[CTRL_MEM_READ]
                      & ex_ctrl_q[CTRL_REG_WRITE];

    assign ra1_dep  = bus.id_uses_ra1 & (bus.id_ra1 == ex_ra1_q);
    assign ra2_dep  = bus.id_uses_ra2 & (bus.id_ra2 == ex_ra1_q);
    assign load_use = ex_is_load & bus.id_valid & (ra1_dep | ra2_dep);

    // Flush always kills; load-use only produces a bubble when EX is not
    // frozen by the external hazard.
    assign insert_bubble = bus.flush | (~bus.hazard & load_use);

    // IF/ID must hold when EX is frozen, or when the dependent instruction
    // has to wait one cycle for the load. A flush discards the decode slot
    // anyway, so load-use alone does not stall under a flush.
    assign bus.stall_id = bus.hazard | (load_use & ~bus.flush);

    // -------------------------------------------------------------------------
    // Writeback bypass: the register file is read in the same cycle it is
    // written, so forward the writeback value into the operand being captured.
    // -------------------------------------------------------------------------
    logic              byp1_hit;
    logic              byp2_hit;
    logic [DATA_W-1:0] rd1_byp;
    logic [DATA_W-1:0] rd2_byp;

    assign byp1_hit = bus.wb_we & bus.id_uses_ra1 & (bus.wb_addr == bus.id_ra1);
    assign byp2_hit = bus.wb_we & bus.id_uses_ra2 & (bus.wb_addr == bus.id_ra2);
    assign rd1_byp  = byp1_hit ? bus.wb_data : bus.id_rd1;
    assign rd2_byp  = byp2_hit ? bus.wb_data : bus.id_rd2;

    // -------------------------------------------------------------------------
    // EX register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q     <= 1'b0;
            ex_rd1_q       <= '0;
            ex_rd2_q       <= '0;
            ex_se_offset_q <= '0;
            ex_opcode_q    <= '0;
            ex_ra1_q       <= '0;
            ex_ra2_q       <= '0;
            ex_fn_offset_q <= '0;
            ex_ctrl_q      <= '0;
        end else if (bus.flush) begin
            // Bubble: only valid and control matter; data fields keep their
            // previous contents to avoid needless toggling.
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
        end else if (bus.hazard) begin
            // Frozen: every EX register holds.
            ex_valid_q <= ex_valid_q;
        end else if (load_use) begin
            // One bubble per load: next cycle EX holds this bubble, so the
            // load-use condition cannot fire again for the same load.
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
        end else begin
            ex_valid_q     <= bus.id_valid;
            ex_rd1_q       <= rd1_byp;
            ex_rd2_q       <= rd2_byp;
            ex_se_offset_q <= bus.id_se_offset;
            ex_opcode_q    <= bus.id_opcode;
            ex_ra1_q       <= bus.id_ra1;
            ex_ra2_q       <= bus.id_ra2;
            ex_fn_offset_q <= bus.id_fn_offset;
            // An empty decode slot must never carry write/memory enables.
            ex_ctrl_q      <= bus.id_valid ? bus.id_ctrl : 6'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Bubble performance counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_count_q <= '0;
        end else if (perf_clr) begin
            bubble_count_q <= '0;
        end else if (insert_bubble && (bubble_count_q != CNT_MAX)) begin
            bubble_count_q <= bubble_count_q + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_rd1       = ex_rd1_q;
    assign bus.ex_rd2       = ex_rd2_q;
    assign bus.ex_se_offset = ex_se_offset_q;
    assign bus.ex_opcode    = ex_opcode_q;
    assign bus.ex_ra1       = ex_ra1_q;
    assign bus.ex_ra2       = ex_ra2_q;
    assign bus.ex_fn_offset = ex_fn_offset_q;
    assign bus.ex_ctrl      = ex_ctrl_q;
    assign bubble_count     = bubble_count_q;

endmodule

// File: tb/tb_id_ex_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_id_ex_pipe_ctrl
//
// Directed bench for id_ex_pipe_ctrl, built with CNT_W=2 so the counter
// saturates quickly. Inputs change 1 ns after the rising edge; registered
// outputs are checked there too, and stall_id is checked once the new inputs
// have settled, before the next edge. exp_cnt tracks the expected counter.
// -----------------------------------------------------------------------------
module tb_id_ex_pipe_ctrl;

    localparam int DATA_W = 16;
    localparam int RA_W   = 4;
    localparam int OP_W   = 4;
    localparam int FN_W   = 4;
    localparam int CNT_W  = 2;

    // -------------------------------------------------------------------------
    // clock / reset
    // -------------------------------------------------------------------------
    logic             clk = 1'b0;
    logic             reset;
    logic             perf_clr;
    logic [CNT_W-1:0] bubble_count;

    always #5 clk = ~clk;

    id_ex_pipe_ctrl_if #(
        .DATA_W(DATA_W), .RA_W(RA_W), .OP_W(OP_W), .FN_W(FN_W)
    ) bus ();

    id_ex_pipe_ctrl #(
        .DATA_W(DATA_W), .RA_W(RA_W), .OP_W(OP_W), .FN_W(FN_W), .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .perf_clr     (perf_clr),
        .bubble_count (bubble_count),
        .bus          (bus)
    );

    // -------------------------------------------------------------------------
    // scoreboard
    // -------------------------------------------------------------------------
    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // driver tasks
    // -------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        bus.id_valid     = 1'b0;
        bus.id_rd1       = '0;
        bus.id_rd2       = '0;
        bus.id_se_offset = '0;
        bus.id_opcode    = '0;
        bus.id_fn_offset = '0;
        bus.id_ra1       = '0;
        bus.id_ra2       = '0;
        bus.id_uses_ra1  = 1'b0;
        bus.id_uses_ra2  = 1'b0;
        bus.id_ctrl      = '0;
        bus.hazard       = 1'b0;
        bus.flush        = 1'b0;
        bus.wb_we        = 1'b0;
        bus.wb_addr      = '0;
        bus.wb_data      = '0;
        perf_clr         = 1'b0;
    endtask

    task automatic instr(input logic [3:0] op, input logic [15:0] rd1,
                         input logic [15:0] rd2, input logic [3:0] ra1,
                         input logic [3:0] ra2, input logic u1, input logic u2,
                         input logic [5:0] ctrl);
        bus.id_valid     = 1'b1;
        bus.id_opcode    = op;
        bus.id_rd1       = rd1;
        bus.id_rd2       = rd2;
        bus.id_ra1       = ra1;
        bus.id_ra2       = ra2;
        bus.id_uses_ra1  = u1;
        bus.id_uses_ra2  = u2;
        bus.id_ctrl      = ctrl;
    endtask

    task automatic bump_cnt();
        if (exp_cnt < 3) exp_cnt++;
    endtask

    // -------------------------------------------------------------------------
    // stimulus
    // -------------------------------------------------------------------------
    initial begin
        idle();

        // ---- reset with garbage inputs ----
        reset = 1'b1;
        instr(4'hF, 16'hDEAD, 16'hBEEF, 4'h7, 4'h9, 1'b1, 1'b1, 6'b111111);
        bus.id_se_offset = 16'h1234;
        bus.id_fn_offset = 4'hA;
        bus.flush        = 1'b1;
        bus.wb_we        = 1'b1;
        bus.wb_data      = 16'h5A5A;
        perf_clr         = 1'b0;
        step();
        step();
        check("rst_ex_valid", bus.ex_valid, 0);
        check("rst_ex_rd1", bus.ex_rd1, 0);
        check("rst_ex_rd2", bus.ex_rd2, 0);
        check("rst_ex_se", bus.ex_se_offset, 0);
        check("rst_ex_opcode", bus.ex_opcode, 0);
        check("rst_ex_ra", {bus.ex_ra1, bus.ex_ra2, bus.ex_fn_offset}, 0);
        check("rst_ex_ctrl", bus.ex_ctrl, 0);
        check("rst_count", bubble_count, 0);

        // ---- first ADD after reset ----
        reset = 1'b0;
        idle();
        instr(4'h1, 16'h0005, 16'h0003, 4'h1, 4'h2, 1'b1, 1'b1, 6'b100000);
        bus.id_se_offset = 16'h0007;
        bus.id_fn_offset = 4'h9;
        settle();
        check("add_stall", bus.stall_id, 0);
        step();
        check("add_valid", bus.ex_valid, 1);
        check("add_opcode", bus.ex_opcode, 4'h1);
        check("add_rd1", bus.ex_rd1, 16'h0005);
        check("add_rd2", bus.ex_rd2, 16'h0003);
        check("add_ctrl", bus.ex_ctrl, 6'b100000);
        check("add_fields", {bus.ex_ra1, bus.ex_ra2, bus.ex_fn_offset}, 12'h129);
        check("add_se", bus.ex_se_offset, 16'h0007);

        // ---- load-use ----
        instr(4'h8, 16'h0100, 16'h0040, 4'h3, 4'h5, 1'b0, 1'b1, 6'b100100);
        settle();
        check("ld_stall", bus.stall_id, 0);
        step();
        check("ld_ctrl", bus.ex_ctrl, 6'b100100);
        check("ld_ra1", bus.ex_ra1, 4'h3);
        instr(4'h2, 16'h0010, 16'h0020, 4'h4, 4'h3, 1'b1, 1'b1, 6'b100000);
        settle();
        check("lu_stall", bus.stall_id, 1);
        step();
        bump_cnt();
        check("lu_bubble_valid", bus.ex_valid, 0);
        check("lu_bubble_ctrl", bus.ex_ctrl, 0);
        check("lu_count", bubble_count, exp_cnt);
        check("lu_after_stall", bus.stall_id, 0);
        step();
        check("dep_valid", bus.ex_valid, 1);
        check("dep_opcode", bus.ex_opcode, 4'h2);
        check("dep_rd2", bus.ex_rd2, 16'h0020);
        check("dep_count", bubble_count, exp_cnt);

        // ---- bypass ----
        instr(4'h3, 16'h1111, 16'h2222, 4'h2, 4'h7, 1'b1, 1'b1, 6'b100000);
        bus.wb_we   = 1'b1;
        bus.wb_addr = 4'h2;
        bus.wb_data = 16'hBEEF;
        step();
        check("byp_rd1_hit", bus.ex_rd1, 16'hBEEF);
        check("byp_rd2_miss", bus.ex_rd2, 16'h2222);
        bus.id_uses_ra1 = 1'b0;
        step();
        check("byp_rd1_unused", bus.ex_rd1, 16'h1111);
        bus.id_uses_ra1 = 1'b1;
        bus.id_ra2      = 4'h2;
        step();
        check("byp_both_rd1", bus.ex_rd1, 16'hBEEF);
        check("byp_both_rd2", bus.ex_rd2, 16'hBEEF);
        bus.wb_we = 1'b0;
        step();
        check("byp_we_off", bus.ex_rd1, 16'h1111);
        bus.wb_addr = '0;
        bus.wb_data = '0;

        // ---- hazard hold ----
        instr(4'h5, 16'hAAAA, 16'h5555, 4'h9, 4'hA, 1'b0, 1'b0, 6'b100000);
        step();
        check("hz_pre_opcode", bus.ex_opcode, 4'h5);
        bus.hazard = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr(4'h6 + 4'(i), 16'($urandom_range(0, 65535)), 16'h0F0F,
                  4'hB, 4'hC, 1'b1, 1'b1, 6'b100000);
            settle();
            check("hz_stall", bus.stall_id, 1);
            step();
            check("hz_opcode", bus.ex_opcode, 4'h5);
            check("hz_rd1", bus.ex_rd1, 16'hAAAA);
            check("hz_valid", bus.ex_valid, 1);
            check("hz_count", bubble_count, exp_cnt);
        end
        bus.hazard = 1'b0;
        instr(4'h7, 16'h7777, 16'h0707, 4'hB, 4'hC, 1'b1, 1'b1, 6'b100000);
        settle();
        check("hz_rel_stall", bus.stall_id, 0);
        step();
        check("hz_rel_opcode", bus.ex_opcode, 4'h7);
        check("hz_rel_rd1", bus.ex_rd1, 16'h7777);

        // ---- lu + hazard: hold ----
        instr(4'h8, 16'h0000, 16'h0000, 4'h6, 4'h1, 1'b0, 1'b1, 6'b100100);
        step();
        check("ld2_ctrl", bus.ex_ctrl, 6'b100100);
        instr(4'h2, 16'h0001, 16'h0002, 4'h6, 4'h1, 1'b1, 1'b0, 6'b100000);
        bus.hazard = 1'b1;
        settle();
        check("luhz_stall", bus.stall_id, 1);
        step();
        check("luhz_ctrl", bus.ex_ctrl, 6'b100100);
        check("luhz_count", bubble_count, exp_cnt);

        // ---- flush + hazard + lu ----
        bus.flush = 1'b1;
        settle();
        check("fl_stall", bus.stall_id, 1);
        step();
        bump_cnt();
        check("fl_valid", bus.ex_valid, 0);
        check("fl_ctrl", bus.ex_ctrl, 0);
        check("fl_count", bubble_count, exp_cnt);

        // ---- flush + lu without hazard ----
        bus.flush  = 1'b0;
        bus.hazard = 1'b0;
        step();
        check("fl_dep_valid", bus.ex_valid, 1);
        instr(4'h8, 16'h0000, 16'h0000, 4'h6, 4'h1, 1'b0, 1'b1, 6'b100100);
        step();
        instr(4'h2, 16'h0001, 16'h0002, 4'h6, 4'h1, 1'b1, 1'b0, 6'b100000);
        bus.flush = 1'b1;
        settle();
        check("fllu_stall", bus.stall_id, 0);
        step();
        bump_cnt();
        check("fllu_valid", bus.ex_valid, 0);
        check("fllu_count", bubble_count, exp_cnt);

        // ---- invalid slot forces ctrl to 0 ----
        bus.flush = 1'b0;
        instr(4'h9, 16'h0000, 16'h0000, 4'hD, 4'hE, 1'b0, 1'b0, 6'b111111);
        bus.id_valid = 1'b0;
        step();
        check("inv_valid", bus.ex_valid, 0);
        check("inv_ctrl", bus.ex_ctrl, 0);
        check("inv_opcode", bus.ex_opcode, 4'h9);

        // ---- counter saturation ----
        idle();
        perf_clr = 1'b1;
        step();
        exp_cnt = 0;
        check("clr_count", bubble_count, exp_cnt);
        perf_clr  = 1'b0;
        bus.flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            bump_cnt();
            check("sat_count", bubble_count, exp_cnt);
        end
        perf_clr = 1'b1;
        step();
        exp_cnt = 0;
        check("clr_bubble_count", bubble_count, exp_cnt);
        perf_clr = 1'b0;
        step();
        bump_cnt();
        check("post_clr_count", bubble_count, exp_cnt);

        // ---- reset mid-operation ----
        bus.flush  = 1'b0;
        instr(4'h4, 16'h4444, 16'h4444, 4'h1, 4'h1, 1'b1, 1'b1, 6'b100000);
        step();
        check("mid_valid_pre", bus.ex_valid, 1);
        bus.hazard = 1'b1;
        reset      = 1'b1;
        step();
        exp_cnt = 0;
        check("mid_rst_valid", bus.ex_valid, 0);
        check("mid_rst_rd1", bus.ex_rd1, 0);
        check("mid_rst_count", bubble_count, exp_cnt);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // -------------------------------------------------------------------------
    // watchdog
    // -------------------------------------------------------------------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/id_ex_pipe_ctrl.md
# id_ex_pipe_ctrl

Parametrised decode-to-execute pipeline register for the 16-bit pipelined core. It captures the decode bundle (operands, offsets, register addresses and control bits), inserts bubbles on load-use hazards and branch flushes, and holds state under an external hazard stall. It bypasses same-cycle writeback data into captured operands and keeps a saturating bubble performance counter. It sits between the IF/ID register/decoder and the ALU/memory stage.

## Interface
- DATA_W, 16, operand and sign-extended offset width
- RA_W, 4, register address width
- OP_W, 4, opcode width
- FN_W, 4, function/offset field width
- CNT_W, 8, bubble counter width
---
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  decode slot holds a real instruction
- id_rd1, id_rd2  in  DATA_W  register-file read data
- id_se_offset  in  DATA_W  sign-extended offset
- id_opcode  in  OP_W; id_fn_offset  in  FN_W
- id_ra1, id_ra2  in  RA_W  register addresses (ra1 is the destination for loads)
- id_uses_ra1, id_uses_ra2  in  1  instruction actually reads that register
- id_ctrl  in  6  {regWrite, r0Write, alusource, memRead, memWrite, memSource}, bit 5 = regWrite, bit 0 = memSource
- hazard  in  1  external stall: freeze EX register
- flush  in  1  branch resolved taken: kill instruction entering EX
- wb_we  in  1; wb_addr  in  RA_W; wb_data  in  DATA_W  writeback port for bypass
- perf_clr  in  1  synchronous clear of bubble_count
- ex_valid  out  1; ex_rd1, ex_rd2, ex_se_offset  out  DATA_W
- ex_opcode  out  OP_W; ex_ra1, ex_ra2  out  RA_W; ex_fn_offset  out  FN_W; ex_ctrl  out  6
- stall_id  out  1  combinational: IF/ID must hold its contents this cycle
- bubble_count  out  CNT_W  saturating count of inserted bubbles

## Operation
- Load-use condition `lu` = ex_valid & ex_ctrl[2] (memRead) & ex_ctrl[5] (regWrite) & id_valid & ((id_uses_ra1 & id_ra1==ex_ra1) | (id_uses_ra2 & id_ra2==ex_ra1)). Address 0 is a real register and is compared normally.
- Per-edge priority:
  - **reset**: all outputs are 0, including bubble_count.
  - **flush**: insert a bubble (ex_valid=0, ex_ctrl=0; data fields may take any value). Flush wins over hazard and lu.
  - **hazard**: all EX registers and bubble_count hold. No bypass is applied.
  - **lu**: insert a bubble.
  - **otherwise**: capture the ID bundle; ex_valid=id_valid. If id_valid=0, ex_ctrl is forced to 0.
- Bypass on capture: if wb_we & id_uses_ra1 & wb_addr==id_ra1, then ex_rd1 gets wb_data. The same rule applies to rd2 with ra2. Both may hit in the same cycle.
- stall_id = hazard | (lu & ~flush).
- bubble_count:
  - Increments by 1 on every edge that inserts a bubble via flush or lu. Reset does not count.
  - Saturates at 2^CNT_W−1.
  - perf_clr zeroes it and takes precedence over an increment.
  - reset also zeroes it.
- Only one bubble is ever inserted per load. On the following cycle EX holds the bubble, so lu is false.

## Timing
- Latency: ID to EX is 1 cycle.
- All outputs except stall_id are registered.
- stall_id is combinational from hazard, flush, id_* and the current EX registers. It must be valid before the same rising edge.
- Reset mid-operation: on the next edge, EX becomes a bubble and the counter clears, regardless of flush or hazard.
- Simultaneous events:
  - flush+hazard: bubble, stall_id=1.
  - flush+lu: one bubble, counter +1, stall_id=0.
  - lu+hazard: hold, counter unchanged, stall_id=1.
- The hazard input is sampled only synchronously; there is no combinational path from hazard to registered outputs.

## Test plan
- **Reset:** hold reset=1 for 2 cycles with garbage inputs. Required: all outputs 0. Release reset, present valid ADD (opcode 4'h1, rd1=16'h0005, rd2=16'h0003, ctrl=6'b100000). Required: next edge ex_valid=1 and those values appear.
- **Load-use:** EX holds a load with ex_ra1=4'h3 and ctrl=6'b100100. ID presents id_ra2=4'h3 with uses_ra2=1. Required: stall_id=1, next edge is a bubble, bubble_count=1. The edge after that captures the dependent instruction and stall_id=0.
- **Bypass:** ID has ra1=4'h2, uses_ra1=1, rd1=16'h1111, with wb_we=1, wb_addr=4'h2, wb_data=16'hBEEF. Required: ex_rd1=16'hBEEF. Repeat with uses_ra1=0. Required: ex_rd1=16'h1111.
- **Hazard:** hold hazard=1 for 3 cycles while ID inputs change. Required: EX outputs unchanged, stall_id=1, counter unchanged. Release hazard. Required: capture resumes on the next edge.
- **Flush priority:** assert flush together with hazard and an lu condition. Required: ex_valid=0, ex_ctrl=0, counter +1, stall_id=1.
- **Counter saturation:** with CNT_W=2, force 5 bubbles. Required: bubble_count sticks at 3. Then assert perf_clr together with a bubble. Required: bubble_count=0.
